// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREAD-port register file for the core, with load-data
// lane selection / extension at write-back and a per-register busy
// scoreboard that holds decode when an operand depends on an outstanding load.
// Optional macro REGFILE_BYPASS_EN: write-through read bypass, and a
// dependent read may proceed in the cycle its load writes back.
module regfile_scoreboard #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     NREGS   = 32,
  parameter int unsigned     NREAD   = 2,
  parameter int unsigned     SP_IDX  = 31,
  parameter logic [XLEN-1:0] SP_INIT = 32'hFFFFFC00,
  localparam int unsigned    AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr_i,
  output logic [NREAD*XLEN-1:0] rd_data_o,
  input  logic [NREAD-1:0]      rd_used_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_load_i,
  input  logic [AW-1:0]         issue_rd_i,
  output logic                  stall_o,
  input  logic                  wb_valid_i,
  input  logic [AW-1:0]         wb_rd_i,
  input  logic                  wb_from_mem_i,
  input  logic [XLEN-1:0]       wb_alu_i,
  input  logic [XLEN-1:0]       wb_mem_i,
  input  logic [1:0]            wb_size_i,
  input  logic                  wb_unsigned_i,
  input  logic [1:0]            wb_off_i,
  output logic [NREGS-1:0]      busy_vec_o,
  output logic [AW:0]           pending_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]  wd;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic             ext_b, ext_h;
  logic [NREAD-1:0] clr_hit;

  // Write-back data: lane select and sign/zero extension of load data
  always_comb begin
    lane_b = wb_mem_i[7:0];
    case (wb_off_i)
      2'd1:    lane_b = wb_mem_i[15:8];
      2'd2:    lane_b = wb_mem_i[23:16];
      2'd3:    lane_b = wb_mem_i[31:24];
      default: lane_b = wb_mem_i[7:0];
    endcase
    // half-word lane follows the upper offset bit only; misaligned bit 0 is dropped
    lane_h = wb_off_i[1] ? wb_mem_i[31:16] : wb_mem_i[15:0];
    ext_b  = ~wb_unsigned_i & lane_b[7];
    ext_h  = ~wb_unsigned_i & lane_h[15];
    wd     = wb_alu_i;
    if (wb_from_mem_i) begin
      case (wb_size_i)
        2'b00:   wd = {{(XLEN-8){ext_b}}, lane_b};
        2'b01:   wd = {{(XLEN-16){ext_h}}, lane_h};
        default: wd = wb_mem_i;
      endcase
    end
  end

  // Register storage: async reset to zero (SP gets its boot value), x0 never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wb_valid_i && (wb_rd_i != '0)) begin
      regs_q[wb_rd_i] <= wd;
    end
  end

  // Per-port flag: this cycle's load write-back resolves the register port k reads
  always_comb begin
    clr_hit = '0;
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NREAD; k++) begin
      clr_hit[k] = wb_valid_i && wb_from_mem_i && (wb_rd_i != '0) &&
                   (wb_rd_i == rd_addr_i[k*AW +: AW]);
    end
`endif
  end

  // Read ports: stored value, optionally overridden by the in-flight write-back
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (wb_valid_i && (wb_rd_i != '0) && (wb_rd_i == rd_addr_i[k*AW +: AW])) begin
        rd_data_o[k*XLEN +: XLEN] = wd;
      end
`endif
    end
    if (!rst) begin
      rd_data_o = '0;
    end
  end

  // Load-use stall: a consumed operand whose load is still outstanding
  always_comb begin
    stall_o = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      if (rd_used_i[k] && busy_q[rd_addr_i[k*AW +: AW]] && !clr_hit[k]) begin
        stall_o = 1'b1;
      end
    end
    if (!rst) begin
      stall_o = 1'b0;
    end
  end

  // Scoreboard next state: a new load issue overrides a same-cycle clear
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i && wb_from_mem_i && (wb_rd_i != '0)) begin
      busy_d[wb_rd_i] = 1'b0;
    end
    if (issue_valid_i && !stall_o && issue_load_i && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the next scoreboard so the count lands with busy_vec
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  // Scoreboard and count registers; reset drops every outstanding load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec_o    = busy_q;
  assign pending_cnt_o = cnt_q;

endmodule
